data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Define DMEM_MISALIGN_CHECK_EN to reject accesses with req_addr[1:0] != 0.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] req_idx;
    logic [AW-1:0] held_idx;
    logic [AW-1:0] load_idx;
    logic          req_bad;
    logic          held_bad;
    logic          held_we;
    logic          load_bad;
    logic          load_we;
    logic          accept;
    logic          enter_resp;
    logic [31:0]   rdata_q;
    logic          err_q;

    assign req_idx = req_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_bad = (|req_addr[31:AW+2]) | (|req_addr[1:0]);
`else
    logic unused_lsb;
    assign unused_lsb = &req_addr[1:0];
    assign req_bad    = |req_addr[31:AW+2];
`endif

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        unique case (state)
            S_IDLE: req_ready = reset;
            S_WAIT: req_ready = 1'b0;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            held_idx <= '0;
            held_bad <= 1'b0;
            held_we  <= 1'b0;
        end else if (accept) begin
            cnt      <= (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
            held_idx <= req_idx;
            held_bad <= req_bad;
            held_we  <= req_we;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With zero latency RESP is entered on the acceptance edge itself,
    // so the live request fields must be used instead of the held ones.
    assign load_idx   = (state == S_IDLE) ? req_idx : held_idx;
    assign load_bad   = (state == S_IDLE) ? req_bad : held_bad;
    assign load_we    = (state == S_IDLE) ? req_we  : held_we;
    assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= load_bad;
            rdata_q <= (load_we | load_bad) ? 32'd0 : mem[load_idx];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with
// LATENCY 2, 0 and 4 exercised through their own request/response ports.
module tb_data_mem_responder;

    localparam int TMO = 60;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int vecs = 0;
    int errs = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(rst[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction; lat counts sampled cycles from the acceptance
    // edge until rsp_valid is seen (TMO on timeout).
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        n = 0;
        while (!req_ready[d] && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        vecs++;
        if (req_ready[0] !== 1'b0) begin
            errs++;
            $display("FAIL reset_req_ready got %b want 0", req_ready[0]);
        end
        vecs++;
        if (rsp_valid[0] !== 1'b0) begin
            errs++;
            $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[0]);
        end
        vecs++;
        if (rsp_rdata[0] !== 32'd0) begin
            errs++;
            $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata[0]);
        end
        vecs++;
        if (rsp_err[0] !== 1'b0) begin
            errs++;
            $display("FAIL reset_rsp_err got %b want 0", rsp_err[0]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (req_ready[i] !== 1'b1) begin
                errs++;
                $display("FAIL release_req_ready[%0d] got %b want 1", i, req_ready[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        vecs++;
        if (er !== 1'b0 || rd !== 32'd0 || lat != 3) begin
            errs++;
            $display("FAIL rt_store err=%b rdata=%h lat=%0d want 0/0/3", er, rd, lat);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (lat != 3) begin
            errs++;
            $display("FAIL rt_load_latency got %0d want 3", lat);
        end
        vecs++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errs++;
            $display("FAIL rt_load_data got %h err=%b want deadbeef err=0", rd, er);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, rd, er, lat);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'hDEAABEEF) begin
            errs++;
            $display("FAIL partial_store got %h want deaabeef", rd);
        end
        xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        vecs++;
        if (er !== 1'b0 || lat != 3) begin
            errs++;
            $display("FAIL zero_be_rsp err=%b lat=%0d want 0/3", er, lat);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'hDEAABEEF) begin
            errs++;
            $display("FAIL zero_be_unchanged got %h want deaabeef", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(0, 1'b1, 32'h0, 32'h0BADF00D, 4'b1111, rd, er, lat);
        xact(0, 1'b0, 32'h400, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errs++;
            $display("FAIL oor_load err=%b rdata=%h want 1/0", er, rd);
        end
        xact(0, 1'b1, 32'h400, 32'h12345678, 4'b1111, rd, er, lat);
        vecs++;
        if (er !== 1'b1) begin
            errs++;
            $display("FAIL oor_store_err got %b want 1", er);
        end
        xact(0, 1'b0, 32'h0, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            errs++;
            $display("FAIL oor_word0 got %h err=%b want 0badf00d err=0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic er;
        int lat;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'h11223344;
`else
        exp_err  = 1'b0;
        exp_word = 32'h55667788;
`endif
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b1111, rd, er, lat);
        xact(0, 1'b1, 32'h13, 32'h55667788, 4'b1111, rd, er, lat);
        vecs++;
        if (er !== exp_err) begin
            errs++;
            $display("FAIL misalign_err got %b want %b", er, exp_err);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== exp_word) begin
            errs++;
            $display("FAIL misalign_word4 got %h want %h", rd, exp_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(0, 1'b1, 32'h24, 32'hA5A50001, 4'b1111, rd, er, lat);
        xact(0, 1'b1, 32'h28, 32'h5A5A0002, 4'b1111, rd, er, lat);
        xact(0, 1'b1, 32'h3FC, 32'h77665544, 4'b0011, rd, er, lat);
        vecs++;
        if (er !== 1'b0) begin
            errs++;
            $display("FAIL b2b_top_store_err got %b want 0", er);
        end
        xact(0, 1'b0, 32'h24, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'hA5A50001) begin
            errs++;
            $display("FAIL b2b_load24 got %h want a5a50001", rd);
        end
        xact(0, 1'b0, 32'h28, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'h5A5A0002) begin
            errs++;
            $display("FAIL b2b_load28 got %h want 5a5a0002", rd);
        end
        xact(0, 1'b1, 32'h3FC, 32'hFFFFFFFF, 4'b1100, rd, er, lat);
        xact(0, 1'b0, 32'h3FC, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'hFFFF5544 || er !== 1'b0) begin
            errs++;
            $display("FAIL b2b_top_word got %h err=%b want ffff5544 err=0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat;
        xact(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd, er, lat);
        vecs++;
        if (lat != 1 || er !== 1'b0) begin
            errs++;
            $display("FAIL zl_store lat=%0d err=%b want 1/0", lat, er);
        end
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h20;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        vecs++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEF00D) begin
            errs++;
            $display("FAIL zl_load_first valid=%b rdata=%h want 1/cafef00d",
                     rsp_valid[1], rsp_rdata[1]);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vecs++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEF00D ||
                rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold[%0d] valid=%b rdata=%h err=%b ready=%b want 1/cafef00d/0/0",
                         i, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]);
            end
        end
        rsp_ready[1] = 1'b1;
        #1;
        vecs++;
        if (req_ready[1] !== 1'b0) begin
            errs++;
            $display("FAIL bp_ready_same_cycle got %b want 0", req_ready[1]);
        end
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        vecs++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            errs++;
            $display("FAIL bp_after ready=%b valid=%b want 1/0", req_ready[1], rsp_valid[1]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic er;
        int lat;
        int seen;
        xact(2, 1'b1, 32'h8, 32'h5A5A5A5A, 4'b1111, rd, er, lat);
        vecs++;
        if (lat != 5) begin
            errs++;
            $display("FAIL l4_store_latency got %0d want 5", lat);
        end
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h8;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[2] === 1'b1) seen++;
            @(posedge clk); #1;
        end
        rst[2] = 1'b0;
        #1;
        vecs++;
        if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b0) begin
            errs++;
            $display("FAIL midrst_outputs ready=%b valid=%b want 0/0", req_ready[2], rsp_valid[2]);
        end
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if (req_ready[2] !== 1'b1) begin
            errs++;
            $display("FAIL midrst_release_ready got %b want 1", req_ready[2]);
        end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2] === 1'b1) seen++;
            @(posedge clk); #1;
        end
        vecs++;
        if (seen != 0) begin
            errs++;
            $display("FAIL midrst_no_rsp valid seen %0d cycles want 0", seen);
        end
        xact(2, 1'b0, 32'h8, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'h5A5A5A5A || er !== 1'b0 || lat != 5) begin
            errs++;
            $display("FAIL midrst_new_load rdata=%h err=%b lat=%0d want 5a5a5a5a/0/5",
                     rd, er, lat);
        end
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'hC;
        req_wdata[2] = 32'h13579BDF;
        req_be[2]    = 4'b1111;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        rst[2]       = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        xact(2, 1'b0, 32'hC, 32'h0, 4'b0000, rd, er, lat);
        vecs++;
        if (rd !== 32'h13579BDF) begin
            errs++;
            $display("FAIL store_before_rst got %h want 13579bdf", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_be[i]    = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        #1;
        test_reset();
        test_round_trip();
        test_partial_store();
        test_out_of_range();
        test_misalign();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
